// File: rtl/sign_extend_if.sv
// ---------------------------------------------------------------------------
// sign_extend_if
//   Bundles the immediate-extension request and result signals.
//   master : drives immediate/mode/in_valid, receives extended/out_valid
//   slave  : the extender itself
// Signals:
//   immediate [15:0]      raw immediate field, bit 15 is the sign bit
//   mode      [1:0]       00 sext, 01 zext, 10 upper (LUI), 11 sext << 2
//   in_valid              immediate/mode valid this cycle
//   extended  [WIDTH-1:0] registered extension result
//   out_valid             extended holds a result from a valid input
// ---------------------------------------------------------------------------
interface sign_extend_if #(
    parameter int WIDTH = 32
);
    logic [15:0]      immediate;
    logic [1:0]       mode;
    logic             in_valid;
    logic [WIDTH-1:0] extended;
    logic             out_valid;

    modport master (
        output immediate,
        output mode,
        output in_valid,
        input  extended,
        input  out_valid
    );

    modport slave (
        input  immediate,
        input  mode,
        input  in_valid,
        output extended,
        output out_valid
    );
endinterface

// File: rtl/sign_extend.sv
// ---------------------------------------------------------------------------
// sign_extend
//   One-cycle registered immediate extender for a WIDTH-bit datapath
//   (WIDTH >= 32). The 16-bit immediate is sign-extended, zero-extended,
//   placed in bits [31:16] (LUI) or sign-extended and shifted left by two
//   (branch offset), selected by mode. No backpressure; every valid input
//   produces a result on the following cycle.
// Ports:
//   clk    : clock, all state updates on the rising edge
//   reset  : synchronous active-high reset, clears result and valid
//   bus    : sign_extend_if slave (immediate, mode, in_valid ->
//            extended, out_valid)
// ---------------------------------------------------------------------------
module sign_extend #(
    parameter int WIDTH = 32
) (
    input  logic          clk,
    input  logic          reset,
    sign_extend_if.slave  bus
);
    // The immediate width is architectural, so it is not a parameter.
    localparam int IMM_WIDTH = 16;

    logic [WIDTH-1:0] sext_s;
    logic [WIDTH-1:0] zext_s;
    logic [WIDTH-1:0] result_s;
    logic [WIDTH-1:0] extended_d;
    logic [WIDTH-1:0] extended_q;
    logic             out_valid_d;
    logic             out_valid_q;

    // Candidate extensions and mode selection.
    // Upper mode reuses the sign-extended value shifted by 16: this puts the
    // immediate in [31:16] and leaves sign copies above bit 31 when WIDTH > 32.
    always_comb begin
        sext_s   = {{(WIDTH-IMM_WIDTH){bus.immediate[IMM_WIDTH-1]}}, bus.immediate};
        zext_s   = {{(WIDTH-IMM_WIDTH){1'b0}}, bus.immediate};
        result_s = sext_s;
        case (bus.mode)
            2'b00:   result_s = sext_s;
            2'b01:   result_s = zext_s;
            2'b10:   result_s = sext_s << 5'd16;
            2'b11:   result_s = sext_s << 5'd2;
            default: result_s = sext_s;
        endcase
    end

    // Next-state: load on valid input, otherwise hold result and drop valid.
    always_comb begin
        extended_d  = extended_q;
        out_valid_d = 1'b0;
        if (bus.in_valid) begin
            extended_d  = result_s;
            out_valid_d = 1'b1;
        end else begin
            extended_d  = extended_q;
            out_valid_d = 1'b0;
        end
    end

    // State registers; reset wins over a simultaneous valid input.
    always_ff @(posedge clk) begin
        if (reset) begin
            extended_q  <= {WIDTH{1'b0}};
            out_valid_q <= 1'b0;
        end else begin
            extended_q  <= extended_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign bus.extended  = extended_q;
    assign bus.out_valid = out_valid_q;
endmodule

// File: tb/tb_sign_extend.sv
module tb_sign_extend;
    typedef struct {
        logic [31:0] e32;
        logic [63:0] e64;
    } exp_t;

    logic clk;
    logic reset;
    int   compared;
    int   mismatched;
    exp_t sb_q[$];
    logic [31:0] last32;
    logic [63:0] last64;

    sign_extend_if #(.WIDTH(32)) bus32 ();
    sign_extend_if #(.WIDTH(64)) bus64 ();

    sign_extend #(.WIDTH(32)) dut32 (.clk(clk), .reset(reset), .bus(bus32));
    sign_extend #(.WIDTH(64)) dut64 (.clk(clk), .reset(reset), .bus(bus64));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference built from signed arithmetic rather than bit concatenation.
    function automatic logic [63:0] model(input logic [15:0] imm, input logic [1:0] m);
        longint s;
        s = longint'($signed(imm));
        case (m)
            2'b00:   return s;
            2'b01:   return {48'h0, imm};
            2'b10:   return s * 64'sd65536;
            default: return s * 64'sd4;
        endcase
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Drive one cycle, push expectation, then check the outputs 1 ns after the edge.
    task automatic step(input logic rst, input logic v, input logic [15:0] imm,
                        input logic [1:0] m, input logic [31:0] e32,
                        input logic [63:0] e64, input string tag);
        exp_t e;
        exp_t got;
        logic exp_v;
        reset           = rst;
        bus32.immediate = imm;  bus64.immediate = imm;
        bus32.mode      = m;    bus64.mode      = m;
        bus32.in_valid  = v;    bus64.in_valid  = v;
        exp_v = !rst && v;
        if (exp_v) begin
            e.e32 = e32;
            e.e64 = e64;
            sb_q.push_back(e);
        end
        @(posedge clk);
        #1;
        check({tag, ".ov32"}, {63'd0, bus32.out_valid}, {63'd0, exp_v});
        check({tag, ".ov64"}, {63'd0, bus64.out_valid}, {63'd0, exp_v});
        if (rst) begin
            last32 = 32'h0;
            last64 = 64'h0;
        end else if (bus32.out_valid && sb_q.size() > 0) begin
            got = sb_q.pop_front();
            last32 = got.e32;
            last64 = got.e64;
        end
        check({tag, ".ext32"}, {32'h0, bus32.extended}, {32'h0, last32});
        check({tag, ".ext64"}, bus64.extended, last64);
    endtask

    initial begin
        logic [15:0] r_imm;
        logic [1:0]  r_m;
        logic [63:0] r_e;
        compared   = 0;
        mismatched = 0;
        last32     = 32'h0;
        last64     = 64'h0;
        reset = 1'b1;
        bus32.immediate = 16'h0; bus64.immediate = 16'h0;
        bus32.mode = 2'b00;      bus64.mode = 2'b00;
        bus32.in_valid = 1'b0;   bus64.in_valid = 1'b0;

        step(1'b1, 1'b0, 16'h0000, 2'b00, 32'h0, 64'h0, "reset0");
        step(1'b1, 1'b1, 16'hFFFF, 2'b00, 32'h0, 64'h0, "reset_valid");
        step(1'b0, 1'b0, 16'h1234, 2'b00, 32'h0, 64'h0, "idle_after_reset");
        step(1'b0, 1'b1, 16'h0000, 2'b00, 32'h00000000, 64'h0000000000000000, "sext_0000");
        step(1'b0, 1'b1, 16'h0001, 2'b00, 32'h00000001, 64'h0000000000000001, "sext_0001");
        step(1'b0, 1'b1, 16'h0008, 2'b00, 32'h00000008, 64'h0000000000000008, "sext_0008");
        step(1'b0, 1'b1, 16'h8000, 2'b00, 32'hFFFF8000, 64'hFFFFFFFFFFFF8000, "sext_8000");
        step(1'b0, 1'b1, 16'h8000, 2'b01, 32'h00008000, 64'h0000000000008000, "zext_8000");
        step(1'b0, 1'b1, 16'h8000, 2'b10, 32'h80000000, 64'hFFFFFFFF80000000, "lui_8000");
        step(1'b0, 1'b1, 16'h8000, 2'b11, 32'hFFFE0000, 64'hFFFFFFFFFFFE0000, "br_8000");
        step(1'b0, 1'b1, 16'h7FFF, 2'b11, 32'h0001FFFC, 64'h000000000001FFFC, "br_7fff");
        step(1'b0, 1'b1, 16'hFFFF, 2'b00, 32'hFFFFFFFF, 64'hFFFFFFFFFFFFFFFF, "sext_ffff");
        step(1'b0, 1'b1, 16'h1234, 2'b10, 32'h12340000, 64'h0000000012340000, "lui_1234");
        step(1'b0, 1'b1, 16'hC001, 2'b11, 32'hFFFF0004, 64'hFFFFFFFFFFFF0004, "br_c001");
        step(1'b0, 1'b1, 16'h8001, 2'b01, 32'h00008001, 64'h0000000000008001, "zext_8001");
        // Hold: no valid input, result stays while out_valid drops.
        step(1'b0, 1'b0, 16'h5555, 2'b00, 32'h0, 64'h0, "hold1");
        step(1'b0, 1'b0, 16'hAAAA, 2'b10, 32'h0, 64'h0, "hold2");
        // Reset with a simultaneous valid input drops the input.
        step(1'b1, 1'b1, 16'h7FFF, 2'b00, 32'h0, 64'h0, "reset_drop");
        step(1'b0, 1'b0, 16'h0000, 2'b00, 32'h0, 64'h0, "idle2");
        step(1'b0, 1'b1, 16'h00FF, 2'b01, 32'h000000FF, 64'h00000000000000FF, "first_after_reset");
        for (int i = 0; i < 12; i++) begin
            r_imm = 16'($urandom);
            r_m   = 2'($urandom_range(0, 3));
            r_e   = model(r_imm, r_m);
            step(1'b0, 1'b1, r_imm, r_m, r_e[31:0], r_e, "random");
        end
        step(1'b0, 1'b0, 16'h0000, 2'b00, 32'h0, 64'h0, "drain");
        check("sb_empty", 64'(sb_q.size()), 64'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
